// File: rtl/tlb_l2_miss_ctrl.sv
// ---------------------------------------------------------------------------
// tlb_l2_miss_ctrl
//
// Front-end controller for the 512-entry 8-way L2 TLB. It takes miss
// requests from the L1 ITLB and DTLB, picks one round-robin, and runs it
// through an L2 lookup. On an L2 miss it asks the page-table walker for a
// translation, writes the walked entry back into the L2 TLB, and returns the
// translation (or a fault) to whichever L1 TLB asked. Only one request is in
// flight at a time.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   itlb_req_* / dtlb_req_*    L1 miss requests (valid/ready, vaddr, perm)
//   itlb_resp_* / dtlb_resp_*  one-cycle response pulse with paddr and fault
//   l2_req_*                   L2 lookup strobe, address and permission
//   l2_hit_i/paddr_i/fault_i   same-cycle lookup result from the L2 array
//   l2_refill_*                write-back of a walked entry into the L2 TLB
//   ptw_req_*                  walk request to the page-table walker
//   ptw_resp_*                 walk completion: paddr, perm, fault
// ---------------------------------------------------------------------------
module tlb_l2_miss_ctrl #(
  parameter int unsigned WALK_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        itlb_req_valid_i,
  output logic        itlb_req_ready_o,
  input  logic [63:0] itlb_req_vaddr_i,
  input  logic [2:0]  itlb_req_perm_i,
  output logic        itlb_resp_valid_o,
  output logic [63:0] itlb_resp_paddr_o,
  output logic        itlb_resp_fault_o,
  input  logic        dtlb_req_valid_i,
  output logic        dtlb_req_ready_o,
  input  logic [63:0] dtlb_req_vaddr_i,
  input  logic [2:0]  dtlb_req_perm_i,
  output logic        dtlb_resp_valid_o,
  output logic [63:0] dtlb_resp_paddr_o,
  output logic        dtlb_resp_fault_o,
  output logic        l2_req_valid_o,
  output logic [63:0] l2_req_vaddr_o,
  output logic [2:0]  l2_req_perm_o,
  input  logic        l2_hit_i,
  input  logic [63:0] l2_paddr_i,
  input  logic        l2_fault_i,
  output logic        l2_refill_valid_o,
  output logic [63:0] l2_refill_vaddr_o,
  output logic [63:0] l2_refill_paddr_o,
  output logic [2:0]  l2_refill_perm_o,
  output logic        ptw_req_valid_o,
  input  logic        ptw_req_ready_i,
  output logic [63:0] ptw_req_vaddr_o,
  input  logic        ptw_resp_valid_i,
  input  logic [63:0] ptw_resp_paddr_i,
  input  logic [2:0]  ptw_resp_perm_i,
  input  logic        ptw_resp_fault_i
);

  localparam int unsigned CNT_W = $clog2(WALK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(WALK_TIMEOUT);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WALK_REQ  = 3'd2;
  localparam logic [2:0] S_WALK_WAIT = 3'd3;
  localparam logic [2:0] S_REFILL    = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             src_q, src_d;       // 0 = ITLB, 1 = DTLB
  logic             ptr_q, ptr_d;       // side that wins a tie; 0 = ITLB
  logic [63:0]      vaddr_q, vaddr_d;
  logic [2:0]       perm_q, perm_d;
  logic [63:0]      paddr_q, paddr_d;
  logic             fault_q, fault_d;
  logic [2:0]       wperm_q, wperm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             grant_i, grant_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  // Grant is decided in the same cycle the requests are seen so an L1 can be
  // accepted without an extra bubble. The pointer only matters on a tie.
  assign grant_i = (state_q == S_IDLE) && itlb_req_valid_i && (!dtlb_req_valid_i || !ptr_q);
  assign grant_d = (state_q == S_IDLE) && dtlb_req_valid_i && (!itlb_req_valid_i ||  ptr_q);

  // The walk counter saturates instead of wrapping; timeout fires on the
  // cycle the counter would reach WALK_TIMEOUT, so the response-to-RESP
  // transition lands exactly WALK_TIMEOUT cycles after entering WALK_REQ.
  assign cnt_inc     = (cnt_q == TIMEOUT_VAL) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == TIMEOUT_VAL);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    vaddr_d = vaddr_q;
    perm_d  = perm_q;
    paddr_d = paddr_q;
    fault_d = fault_q;
    wperm_d = wperm_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (grant_i || grant_d) begin
          src_d   = grant_d;
          ptr_d   = grant_i;
          vaddr_d = grant_d ? dtlb_req_vaddr_i : itlb_req_vaddr_i;
          perm_d  = grant_d ? dtlb_req_perm_i  : itlb_req_perm_i;
          paddr_d = '0;
          fault_d = 1'b0;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (l2_hit_i) begin
          paddr_d = l2_paddr_i;
          fault_d = l2_fault_i;
          state_d = S_RESP;
        end else begin
          cnt_d   = '0;
          state_d = S_WALK_REQ;
        end
      end
      S_WALK_REQ: begin
        cnt_d = cnt_inc;
        // Timeout beats a same-cycle handshake: the request is simply dropped.
        if (timeout_hit) begin
          paddr_d = '0;
          fault_d = 1'b1;
          state_d = S_RESP;
        end else if (ptw_req_ready_i) begin
          state_d = S_WALK_WAIT;
        end
      end
      S_WALK_WAIT: begin
        cnt_d = cnt_inc;
        // A response in the timeout cycle still counts.
        if (ptw_resp_valid_i) begin
          if (ptw_resp_fault_i) begin
            paddr_d = '0;
            fault_d = 1'b1;
            state_d = S_RESP;
          end else begin
            paddr_d = ptw_resp_paddr_i;
            wperm_d = ptw_resp_perm_i;
            state_d = S_REFILL;
          end
        end else if (timeout_hit) begin
          paddr_d = '0;
          fault_d = 1'b1;
          state_d = S_RESP;
        end
      end
      S_REFILL: begin
        // Fault when the walked entry lacks any permission the L1 asked for.
        fault_d = |(perm_q & ~wperm_q);
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= 1'b0;
      ptr_q   <= 1'b0;
      vaddr_q <= '0;
      perm_q  <= '0;
      paddr_q <= '0;
      fault_q <= 1'b0;
      wperm_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      vaddr_q <= vaddr_d;
      perm_q  <= perm_d;
      paddr_q <= paddr_d;
      fault_q <= fault_d;
      wperm_q <= wperm_d;
      cnt_q   <= cnt_d;
    end
  end

  assign itlb_req_ready_o  = grant_i;
  assign dtlb_req_ready_o  = grant_d;

  // Response payloads are forced to zero whenever that side is not pulsing.
  assign itlb_resp_valid_o = (state_q == S_RESP) && !src_q;
  assign dtlb_resp_valid_o = (state_q == S_RESP) &&  src_q;
  assign itlb_resp_paddr_o = itlb_resp_valid_o ? paddr_q : '0;
  assign itlb_resp_fault_o = itlb_resp_valid_o && fault_q;
  assign dtlb_resp_paddr_o = dtlb_resp_valid_o ? paddr_q : '0;
  assign dtlb_resp_fault_o = dtlb_resp_valid_o && fault_q;

  assign l2_req_valid_o    = (state_q == S_LOOKUP);
  assign l2_req_vaddr_o    = l2_req_valid_o ? vaddr_q : '0;
  assign l2_req_perm_o     = l2_req_valid_o ? perm_q  : '0;

  assign l2_refill_valid_o = (state_q == S_REFILL);
  assign l2_refill_vaddr_o = l2_refill_valid_o ? vaddr_q : '0;
  assign l2_refill_paddr_o = l2_refill_valid_o ? paddr_q : '0;
  assign l2_refill_perm_o  = l2_refill_valid_o ? wperm_q : '0;

  assign ptw_req_valid_o   = (state_q == S_WALK_REQ);
  assign ptw_req_vaddr_o   = ptw_req_valid_o ? vaddr_q : '0;

endmodule

// File: tb/tb_tlb_l2_miss_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for tlb_l2_miss_ctrl. Each transaction is described by a handful
// of fields (who requests, hit or miss, PTW ready delay, PTW response delay,
// walk fault, ...). The expected cycle of every strobe and the response
// payload are worked out arithmetically from the latency rules, then the DUT
// outputs are compared cycle by cycle against that expectation.
// ---------------------------------------------------------------------------
module tb_tlb_l2_miss_ctrl;

   localparam int TO = 8;
   localparam int WIN = TO + 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        itlb_req_valid_i, itlb_req_ready_o;
   logic [63:0] itlb_req_vaddr_i;
   logic [2:0]  itlb_req_perm_i;
   logic        itlb_resp_valid_o;
   logic [63:0] itlb_resp_paddr_o;
   logic        itlb_resp_fault_o;
   logic        dtlb_req_valid_i, dtlb_req_ready_o;
   logic [63:0] dtlb_req_vaddr_i;
   logic [2:0]  dtlb_req_perm_i;
   logic        dtlb_resp_valid_o;
   logic [63:0] dtlb_resp_paddr_o;
   logic        dtlb_resp_fault_o;
   logic        l2_req_valid_o;
   logic [63:0] l2_req_vaddr_o;
   logic [2:0]  l2_req_perm_o;
   logic        l2_hit_i;
   logic [63:0] l2_paddr_i;
   logic        l2_fault_i;
   logic        l2_refill_valid_o;
   logic [63:0] l2_refill_vaddr_o, l2_refill_paddr_o;
   logic [2:0]  l2_refill_perm_o;
   logic        ptw_req_valid_o, ptw_req_ready_i;
   logic [63:0] ptw_req_vaddr_o;
   logic        ptw_resp_valid_i;
   logic [63:0] ptw_resp_paddr_i;
   logic [2:0]  ptw_resp_perm_i;
   logic        ptw_resp_fault_i;

   int checks = 0;
   int errors = 0;

   // Transaction description shared by the stimulus task
   bit          tIv, tDv, tHit, tL2Fault, tNoResp, tWalkFault, tLate, tSpurious;
   logic [63:0] tIva, tDva, tL2Paddr, tWPaddr;
   logic [2:0]  tIperm, tDperm, tWPerm;
   int          tD, tK, tAbortAt;

   // Reference arbitration pointer: 1 means DTLB wins a tie
   bit ptrIsD;

   tlb_l2_miss_ctrl #(.WALK_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .itlb_req_valid_i(itlb_req_valid_i), .itlb_req_ready_o(itlb_req_ready_o),
      .itlb_req_vaddr_i(itlb_req_vaddr_i), .itlb_req_perm_i(itlb_req_perm_i),
      .itlb_resp_valid_o(itlb_resp_valid_o), .itlb_resp_paddr_o(itlb_resp_paddr_o),
      .itlb_resp_fault_o(itlb_resp_fault_o),
      .dtlb_req_valid_i(dtlb_req_valid_i), .dtlb_req_ready_o(dtlb_req_ready_o),
      .dtlb_req_vaddr_i(dtlb_req_vaddr_i), .dtlb_req_perm_i(dtlb_req_perm_i),
      .dtlb_resp_valid_o(dtlb_resp_valid_o), .dtlb_resp_paddr_o(dtlb_resp_paddr_o),
      .dtlb_resp_fault_o(dtlb_resp_fault_o),
      .l2_req_valid_o(l2_req_valid_o), .l2_req_vaddr_o(l2_req_vaddr_o),
      .l2_req_perm_o(l2_req_perm_o),
      .l2_hit_i(l2_hit_i), .l2_paddr_i(l2_paddr_i), .l2_fault_i(l2_fault_i),
      .l2_refill_valid_o(l2_refill_valid_o), .l2_refill_vaddr_o(l2_refill_vaddr_o),
      .l2_refill_paddr_o(l2_refill_paddr_o), .l2_refill_perm_o(l2_refill_perm_o),
      .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
      .ptw_req_vaddr_o(ptw_req_vaddr_o),
      .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_paddr_i(ptw_resp_paddr_i),
      .ptw_resp_perm_i(ptw_resp_perm_i), .ptw_resp_fault_i(ptw_resp_fault_i)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Quiesce every DUT input
   task automatic driveIdle();
      itlb_req_valid_i = 1'b0; itlb_req_vaddr_i = '0; itlb_req_perm_i = '0;
      dtlb_req_valid_i = 1'b0; dtlb_req_vaddr_i = '0; dtlb_req_perm_i = '0;
      l2_hit_i = 1'b0; l2_paddr_i = '0; l2_fault_i = 1'b0;
      ptw_req_ready_i = 1'b0; ptw_resp_valid_i = 1'b0;
      ptw_resp_paddr_i = '0; ptw_resp_perm_i = '0; ptw_resp_fault_i = 1'b0;
   endtask

   // Every output must read zero while held in reset
   task automatic checkAllZero(input string where);
      checkOutput({where, " itlb_ready"}, itlb_req_ready_o, 0);
      checkOutput({where, " dtlb_ready"}, dtlb_req_ready_o, 0);
      checkOutput({where, " itlb_resp_valid"}, itlb_resp_valid_o, 0);
      checkOutput({where, " itlb_resp_paddr"}, itlb_resp_paddr_o, 0);
      checkOutput({where, " itlb_resp_fault"}, itlb_resp_fault_o, 0);
      checkOutput({where, " dtlb_resp_valid"}, dtlb_resp_valid_o, 0);
      checkOutput({where, " dtlb_resp_paddr"}, dtlb_resp_paddr_o, 0);
      checkOutput({where, " dtlb_resp_fault"}, dtlb_resp_fault_o, 0);
      checkOutput({where, " l2_req_valid"}, l2_req_valid_o, 0);
      checkOutput({where, " l2_req_vaddr"}, l2_req_vaddr_o, 0);
      checkOutput({where, " l2_req_perm"}, l2_req_perm_o, 0);
      checkOutput({where, " refill_valid"}, l2_refill_valid_o, 0);
      checkOutput({where, " refill_vaddr"}, l2_refill_vaddr_o, 0);
      checkOutput({where, " refill_paddr"}, l2_refill_paddr_o, 0);
      checkOutput({where, " refill_perm"}, l2_refill_perm_o, 0);
      checkOutput({where, " ptw_req_valid"}, ptw_req_valid_o, 0);
      checkOutput({where, " ptw_req_vaddr"}, ptw_req_vaddr_o, 0);
   endtask

   // Full reset pulse; the reference pointer returns to ITLB
   task automatic applyReset();
      @(negedge clk);
      driveIdle();
      rst_n = 1'b0;
      @(negedge clk);
      #1 checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      ptrIsD = 1'b0;
   endtask

   // Default, harmless transaction description
   task automatic clearTxn();
      tIv = 0; tDv = 0; tHit = 0; tL2Fault = 0; tNoResp = 0; tWalkFault = 0;
      tLate = 0; tSpurious = 0;
      tIva = '0; tDva = '0; tL2Paddr = '0; tWPaddr = '0;
      tIperm = '0; tDperm = '0; tWPerm = '0;
      tD = 0; tK = 0; tAbortAt = -1;
   endtask

   // Run one transaction. Cycle 0 is the accept cycle; cycle 1 the lookup;
   // the walk begins at cycle 2 and its counter expires at cycle 2+TO.
   task automatic applyStimulus();
      bit          winD, timedOut;
      logic [63:0] va, ePaddr;
      logic [2:0]  pm;
      logic        eFault;
      int          respC, refillC, ptwEnd, respInC, lateC;

      winD = (tIv && tDv) ? ptrIsD : tDv;
      ptrIsD = !winD;
      va = winD ? tDva : tIva;
      pm = winD ? tDperm : tIperm;
      respC = -1; refillC = -1; ptwEnd = -1; respInC = -1; lateC = -1;
      ePaddr = '0; eFault = 1'b0; timedOut = 1'b0;

      if (tHit) begin
         respC = 2; ePaddr = tL2Paddr; eFault = tL2Fault;
      end else if (tD > TO - 2) begin
         timedOut = 1'b1; ptwEnd = TO + 1;
      end else begin
         ptwEnd = 2 + tD;
         respInC = tNoResp ? -1 : 3 + tD + tK;
         if (tNoResp || (tD + tK > TO - 2)) begin
            timedOut = 1'b1;
         end else if (tWalkFault) begin
            respC = 4 + tD + tK; ePaddr = '0; eFault = 1'b1;
         end else begin
            refillC = 4 + tD + tK; respC = 5 + tD + tK;
            ePaddr = tWPaddr; eFault = |(pm & ~tWPerm);
         end
      end
      if (timedOut) begin
         respC = TO + 2; ePaddr = '0; eFault = 1'b1;
         lateC = tLate ? TO + 3 : -1;
      end

      for (int c = 0; c <= WIN; c++) begin
         @(negedge clk);
         itlb_req_valid_i = (c == 0) && tIv;
         dtlb_req_valid_i = (c == 0) && tDv;
         itlb_req_vaddr_i = tIva; itlb_req_perm_i = tIperm;
         dtlb_req_vaddr_i = tDva; dtlb_req_perm_i = tDperm;
         l2_hit_i = tHit; l2_paddr_i = tL2Paddr; l2_fault_i = tL2Fault;
         ptw_req_ready_i = !tHit && (c >= 2 + tD);
         ptw_resp_valid_i = (c == respInC) || (c == lateC) || (c == 1 && tSpurious);
         ptw_resp_paddr_i = tWPaddr; ptw_resp_perm_i = tWPerm; ptw_resp_fault_i = tWalkFault;

         if (c == tAbortAt) begin
            driveIdle();
            rst_n = 1'b0;
            #1 checkAllZero("midreset");
            @(negedge clk);
            rst_n = 1'b1;
            ptrIsD = 1'b0;
            return;
         end

         #1;
         if (c == 0) begin
            checkOutput("itlb_ready", itlb_req_ready_o, !winD);
            checkOutput("dtlb_ready", dtlb_req_ready_o, winD);
         end
         checkOutput($sformatf("l2_req_valid c%0d", c), l2_req_valid_o, c == 1);
         if (c == 1) begin
            checkOutput("l2_req_vaddr", l2_req_vaddr_o, va);
            checkOutput("l2_req_perm", l2_req_perm_o, pm);
         end
         checkOutput($sformatf("ptw_req_valid c%0d", c), ptw_req_valid_o, !tHit && c >= 2 && c <= ptwEnd);
         if (!tHit && c >= 2 && c <= ptwEnd)
            checkOutput("ptw_req_vaddr", ptw_req_vaddr_o, va);
         checkOutput($sformatf("refill_valid c%0d", c), l2_refill_valid_o, c == refillC);
         if (c == refillC) begin
            checkOutput("refill_vaddr", l2_refill_vaddr_o, va);
            checkOutput("refill_paddr", l2_refill_paddr_o, tWPaddr);
            checkOutput("refill_perm", l2_refill_perm_o, tWPerm);
         end
         checkOutput($sformatf("itlb_resp_valid c%0d", c), itlb_resp_valid_o, c == respC && !winD);
         checkOutput($sformatf("dtlb_resp_valid c%0d", c), dtlb_resp_valid_o, c == respC && winD);
         checkOutput($sformatf("itlb_resp_paddr c%0d", c), itlb_resp_paddr_o, (c == respC && !winD) ? ePaddr : 64'd0);
         checkOutput($sformatf("itlb_resp_fault c%0d", c), itlb_resp_fault_o, c == respC && !winD && eFault);
         checkOutput($sformatf("dtlb_resp_paddr c%0d", c), dtlb_resp_paddr_o, (c == respC && winD) ? ePaddr : 64'd0);
         checkOutput($sformatf("dtlb_resp_fault c%0d", c), dtlb_resp_fault_o, c == respC && winD && eFault);
      end
      @(negedge clk);
      driveIdle();
   endtask

   // Directed scenarios first, then a randomized mix
   initial begin
      driveIdle();
      rst_n = 1'b0;
      ptrIsD = 1'b0;
      #1 checkAllZero("por");
      applyReset();

      // L2 hit from the ITLB
      clearTxn(); tIv = 1; tIva = 64'h1000; tIperm = 3'b001;
      tHit = 1; tL2Paddr = 64'h8000_1000;
      applyStimulus();

      // DTLB miss, PTW answers 3 cycles into the wait, refill then response
      clearTxn(); tDv = 1; tDva = 64'h2000; tDperm = 3'b010;
      tK = 3; tWPaddr = 64'h9000_2000; tWPerm = 3'b011;
      applyStimulus();

      // Walk succeeds but lacks the requested permission
      clearTxn(); tIv = 1; tIva = 64'h3000; tIperm = 3'b100;
      tK = 1; tWPaddr = 64'h9000_3000; tWPerm = 3'b011;
      applyStimulus();

      // Arbitration after reset: ITLB, DTLB, ITLB
      applyReset();
      for (int i = 0; i < 3; i++) begin
         clearTxn(); tIv = 1; tDv = 1; tHit = 1;
         tIva = 64'hA000 + 64'(i); tDva = 64'hB000 + 64'(i);
         tL2Paddr = 64'hC000 + 64'(i);
         applyStimulus();
      end

      // PTW never answers; a late response afterwards must be ignored
      clearTxn(); tDv = 1; tDva = 64'h4000; tDperm = 3'b001;
      tNoResp = 1; tLate = 1; tWPaddr = 64'h9000_4000; tWPerm = 3'b111;
      applyStimulus();

      // Response exactly in the timeout cycle still wins
      clearTxn(); tIv = 1; tIva = 64'h5000; tIperm = 3'b001;
      tD = 1; tK = TO - 3; tWPaddr = 64'h9000_5000; tWPerm = 3'b001;
      applyStimulus();

      // Reset while waiting on the walker, then a normal ITLB request
      clearTxn(); tDv = 1; tDva = 64'h6000; tDperm = 3'b001;
      tK = 5; tAbortAt = 4; tWPaddr = 64'h9000_6000; tWPerm = 3'b001;
      applyStimulus();
      clearTxn(); tIv = 1; tDv = 1; tIva = 64'h7000; tDva = 64'h7100;
      tHit = 1; tL2Paddr = 64'h8000_7000;
      applyStimulus();

      for (int n = 0; n < 60; n++) begin
         int sel;
         clearTxn();
         sel = $urandom_range(0, 2);
         tIv = (sel != 1);
         tDv = (sel != 0);
         tIva = {$urandom, $urandom}; tDva = {$urandom, $urandom};
         tIperm = 3'($urandom_range(0, 7)); tDperm = 3'($urandom_range(0, 7));
         tHit = ($urandom_range(0, 2) == 0);
         tL2Paddr = {$urandom, $urandom}; tL2Fault = ($urandom_range(0, 3) == 0);
         tD = ($urandom_range(0, 4) == 0) ? $urandom_range(0, TO) : $urandom_range(0, 2);
         tK = $urandom_range(0, TO - 1);
         tNoResp = ($urandom_range(0, 5) == 0);
         tWalkFault = ($urandom_range(0, 3) == 0);
         tLate = ($urandom_range(0, 1) == 1);
         tSpurious = ($urandom_range(0, 1) == 1);
         tWPaddr = {$urandom, $urandom}; tWPerm = 3'($urandom_range(0, 7));
         applyStimulus();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
